// File: rtl/fpu_mem_pkg.sv
// Shared definitions for the FPU memory-side blocks.
//   pf_state_t : line prefetcher control states
//   LINE_BITS  : width of one DRAM line (64 bytes)
//   LINE_SHIFT : log2 of the line size in bytes
package fpu_mem_pkg;

  localparam int LINE_BITS  = 512;
  localparam int LINE_SHIFT = 6;

  typedef enum logic [1:0] {
    PF_IDLE      = 2'd0,
    PF_FETCH     = 2'd1,
    PF_WAIT_DONE = 2'd2
  } pf_state_t;

endpackage

// File: rtl/line_fifo.sv
// Circular FIFO holding whole lines for the prefetcher.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write din at the tail (ignored when full)
//   pop        : advance the head (ignored when empty)
//   dout       : head entry, all zeros when empty
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module line_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PINC_C  = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PINC_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PINC_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Line storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Head read; forced to zero when empty so stale lines never leak out.
  always_comb begin
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/fpu_line_prefetch.sv
// Read-side line prefetcher between the FPU datapath and the FPU DMA.
// Accepts {base address, line count}, requests that many 64-byte lines from
// the DMA and buffers them in a line FIFO drained by a valid/ready stream.
//   cmd_*            : command from the FPU sequencer
//   request, rd_wr, address, request_size, fpu_ready, write_data : to DMA
//   dram_ready, request_done, read_data                          : from DMA
//   line_valid/ready/data/last : drain stream to the FPU
//   ovf_err          : sticky, a line arrived while the FIFO was full
module fpu_line_prefetch
  import fpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int SIZE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [SIZE_WIDTH-1:0] cmd_lines,
  output logic                  request,
  output logic                  rd_wr,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [SIZE_WIDTH-1:0] request_size,
  output logic                  fpu_ready,
  output logic [LINE_BITS-1:0]  write_data,
  input  logic                  dram_ready,
  input  logic                  request_done,
  input  logic [LINE_BITS-1:0]  read_data,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic [LINE_BITS-1:0]  line_data,
  output logic                  line_last,
  output logic                  ovf_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         TWO_C   = CW'(2);
  localparam logic [SIZE_WIDTH-1:0] ONE_C   = SIZE_WIDTH'(1);

  pf_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] rcv_cnt_q, rcv_cnt_d;
  logic                  ovf_q, ovf_d;

  logic                  push_req_s;
  logic                  last_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic [LINE_BITS:0]    fifo_dout_s;
  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CW-1:0]         free_s;
  logic                  addr_lo_unused_s;

  // Sub-line address bits are deliberately discarded.
  assign addr_lo_unused_s = ^cmd_addr[LINE_SHIFT-1:0];

  assign free_s = DEPTH_C - fifo_count_s;

  // Control FSM: next state, latched command and DMA handshake outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    rcv_cnt_d  = rcv_cnt_q;
    cmd_ready  = 1'b0;
    request    = 1'b0;
    fpu_ready  = 1'b0;
    push_req_s = 1'b0;
    last_s     = 1'b0;
    case (state_q)
      PF_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_lines != {SIZE_WIDTH{1'b0}})) begin
          addr_d    = {cmd_addr[ADDR_WIDTH-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
          size_d    = cmd_lines;
          rcv_cnt_d = {SIZE_WIDTH{1'b0}};
          state_d   = PF_FETCH;
        end else begin
          // Zero-length commands are accepted and simply dropped.
          state_d = PF_IDLE;
        end
      end
      PF_FETCH: begin
        request = 1'b1;
        // Keep one slot spare for a line the DMA may already have in flight.
        fpu_ready = (free_s >= TWO_C);
        if (dram_ready) begin
          push_req_s = 1'b1;
          last_s     = (rcv_cnt_q == (size_q - ONE_C));
          rcv_cnt_d  = rcv_cnt_q + ONE_C;
          if (last_s) begin
            state_d = PF_WAIT_DONE;
          end else begin
            state_d = PF_FETCH;
          end
        end else begin
          state_d = PF_FETCH;
        end
      end
      PF_WAIT_DONE: begin
        if (request_done) begin
          state_d = PF_IDLE;
        end else begin
          state_d = PF_WAIT_DONE;
        end
      end
      default: begin
        state_d = PF_IDLE;
      end
    endcase
  end

  // Overflow is a push attempt against a full FIFO; the line is dropped.
  always_comb begin
    fifo_push_s = push_req_s && !fifo_full_s;
    fifo_pop_s  = line_valid && line_ready;
    if (push_req_s && fifo_full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PF_IDLE;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      size_q    <= {SIZE_WIDTH{1'b0}};
      rcv_cnt_q <= {SIZE_WIDTH{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      rcv_cnt_q <= rcv_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  line_fifo #(
    .WIDTH (LINE_BITS + 1),
    .DEPTH (DEPTH)
  ) u_line_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   ({last_s, read_data}),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign rd_wr        = 1'b0;
  assign write_data   = {LINE_BITS{1'b0}};
  assign address      = addr_q;
  assign request_size = size_q;
  assign ovf_err      = ovf_q;
  assign line_valid   = !fifo_empty_s;
  assign line_data    = fifo_dout_s[LINE_BITS-1:0];
  assign line_last    = fifo_dout_s[LINE_BITS];

endmodule

// File: tb/tb_fpu_line_prefetch.sv
module tb_fpu_line_prefetch;
  import fpu_mem_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int SW    = 8;

  logic           clk;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [AW-1:0]  cmd_addr;
  logic [SW-1:0]  cmd_lines;
  logic           request;
  logic           rd_wr;
  logic [AW-1:0]  address;
  logic [SW-1:0]  request_size;
  logic           fpu_ready;
  logic [511:0]   write_data;
  logic           dram_ready;
  logic           request_done;
  logic [511:0]   read_data;
  logic           line_valid;
  logic           line_ready;
  logic [511:0]   line_data;
  logic           line_last;
  logic           ovf_err;

  int n_total = 0;
  int n_pass  = 0;

  fpu_line_prefetch #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_lines(cmd_lines),
    .request(request), .rd_wr(rd_wr), .address(address), .request_size(request_size),
    .fpu_ready(fpu_ready), .write_data(write_data),
    .dram_ready(dram_ready), .request_done(request_done), .read_data(read_data),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
    .line_last(line_last), .ovf_err(ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  // FIFO contents as a queue; the command is tracked as "lines still owed"
  // plus a flag for "all lines received, waiting for the DMA to finish".
  logic [512:0] mq[$];
  int           m_rem;
  bit           m_wait;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_size;
  bit           m_ovf;

  function automatic void model_step();
    bit was_idle, was_fetch, was_wait, lst;
    int old;
    if (!rst_n) begin
      mq.delete();
      m_rem = 0; m_wait = 0; m_addr = '0; m_size = '0; m_ovf = 0;
    end else begin
      was_idle  = (m_rem == 0) && !m_wait;
      was_fetch = (m_rem > 0);
      was_wait  = m_wait && (m_rem == 0);
      old       = mq.size();
      if (old > 0 && line_ready) void'(mq.pop_front());
      if (was_fetch && dram_ready) begin
        lst = (m_rem == 1);
        if (old == DEPTH) m_ovf = 1;
        else mq.push_back({lst, read_data});
        m_rem--;
        if (lst) m_wait = 1;
      end
      if (was_wait && request_done) m_wait = 0;
      if (was_idle && cmd_valid && cmd_lines != 0) begin
        m_rem  = int'(cmd_lines);
        m_addr = {cmd_addr[AW-1:6], 6'b0};
        m_size = cmd_lines;
      end
    end
  endfunction

  task automatic compare_model();
    bit idle, fetch;
    logic [512:0] head;
    idle  = (m_rem == 0) && !m_wait;
    fetch = (m_rem > 0);
    head  = (mq.size() != 0) ? mq[0] : '0;
    chk("m cmd_ready", cmd_ready, idle);
    chk("m request", request, fetch);
    chk("m fpu_ready", fpu_ready, fetch && ((DEPTH - mq.size()) >= 2));
    chk("m line_valid", line_valid, mq.size() != 0);
    chk("m line_last", line_last, head[512]);
    chk("m line_data", line_data, head[511:0]);
    chk("m address", address, m_addr);
    chk("m request_size", request_size, m_size);
    chk("m ovf_err", ovf_err, m_ovf);
    chk("m rd_wr", rd_wr, 1'b0);
    chk("m write_data", write_data, 512'd0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic clear_inputs();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_lines = '0;
    dram_ready = 1'b0; request_done = 1'b0; read_data = '0; line_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [SW-1:0] n);
    cmd_valid = 1'b1; cmd_addr = a; cmd_lines = n;
    cycle();
    cmd_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          cmd_valid;
    logic [31:0]   cmd_addr;
    logic [7:0]    cmd_lines;
    logic          dram_ready;
    logic          request_done;
    logic          line_ready;
    logic [31:0]   tag;
    logic          e_cmd_ready;
    logic          e_request;
    logic          e_fpu_ready;
    logic          e_line_valid;
    logic          e_line_last;
    logic [31:0]   e_address;
    logic [7:0]    e_size;
    logic [31:0]   e_head;
  } vec_t;

  function automatic vec_t mk(input logic cv, input logic [31:0] ca, input logic [7:0] cl,
                              input logic dr, input logic rd, input logic lr, input logic [31:0] tg,
                              input logic ecr, input logic erq, input logic efr, input logic elv,
                              input logic ell, input logic [31:0] ea, input logic [7:0] es,
                              input logic [31:0] eh);
    vec_t v;
    v.cmd_valid = cv; v.cmd_addr = ca; v.cmd_lines = cl; v.dram_ready = dr;
    v.request_done = rd; v.line_ready = lr; v.tag = tg;
    v.e_cmd_ready = ecr; v.e_request = erq; v.e_fpu_ready = efr; v.e_line_valid = elv;
    v.e_line_last = ell; v.e_address = ea; v.e_size = es; v.e_head = eh;
    return v;
  endfunction

  vec_t vecs[10];
  int   delivered;

  initial begin
    // Basic fetch of 3 lines followed by a zero-length command.
    vecs[0] = mk(0, 32'h0, 8'd0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         8'd0, 32'h0);
    vecs[1] = mk(1, 32'h1000_0047, 8'd3, 0, 0, 0, 32'h0, 0, 1, 1, 0, 0, 32'h1000_0040, 8'd3, 32'h0);
    vecs[2] = mk(0, 32'h0, 8'd0, 1, 0, 0, 32'hA1A1_0001, 0, 1, 1, 1, 0, 32'h1000_0040, 8'd3, 32'hA1A1_0001);
    vecs[3] = mk(0, 32'h0, 8'd0, 1, 0, 0, 32'hA2A2_0002, 0, 1, 1, 1, 0, 32'h1000_0040, 8'd3, 32'hA1A1_0001);
    vecs[4] = mk(0, 32'h0, 8'd0, 1, 0, 0, 32'hA3A3_0003, 0, 0, 0, 1, 0, 32'h1000_0040, 8'd3, 32'hA1A1_0001);
    vecs[5] = mk(0, 32'h0, 8'd0, 0, 0, 1, 32'h0,         0, 0, 0, 1, 0, 32'h1000_0040, 8'd3, 32'hA2A2_0002);
    vecs[6] = mk(0, 32'h0, 8'd0, 0, 1, 1, 32'h0,         1, 0, 0, 1, 1, 32'h1000_0040, 8'd3, 32'hA3A3_0003);
    vecs[7] = mk(0, 32'h0, 8'd0, 0, 0, 1, 32'h0,         1, 0, 0, 0, 0, 32'h1000_0040, 8'd3, 32'h0);
    vecs[8] = mk(1, 32'h2000_0080, 8'd0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h1000_0040, 8'd3, 32'h0);
    vecs[9] = mk(0, 32'h0, 8'd0, 1, 0, 0, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 32'h1000_0040, 8'd3, 32'h0);

    clear_inputs();
    rst_n = 1'b0;
    cycle();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cmd_valid    = vecs[i].cmd_valid;
      cmd_addr     = vecs[i].cmd_addr;
      cmd_lines    = vecs[i].cmd_lines;
      dram_ready   = vecs[i].dram_ready;
      request_done = vecs[i].request_done;
      line_ready   = vecs[i].line_ready;
      read_data    = {16{vecs[i].tag}};
      cycle();
      chk($sformatf("vec%0d cmd_ready", i), cmd_ready, vecs[i].e_cmd_ready);
      chk($sformatf("vec%0d request", i), request, vecs[i].e_request);
      chk($sformatf("vec%0d fpu_ready", i), fpu_ready, vecs[i].e_fpu_ready);
      chk($sformatf("vec%0d line_valid", i), line_valid, vecs[i].e_line_valid);
      chk($sformatf("vec%0d line_last", i), line_last, vecs[i].e_line_last);
      chk($sformatf("vec%0d address", i), address, vecs[i].e_address);
      chk($sformatf("vec%0d request_size", i), request_size, vecs[i].e_size);
      chk($sformatf("vec%0d line_data", i), line_data, {16{vecs[i].e_head}});
    end

    // Backpressure: fpu_ready drops at 3 held lines; one in-flight line fills slot 4.
    do_reset();
    issue(32'h0000_0100, 8'd6);
    for (int i = 0; i < 3; i++) begin
      dram_ready = 1'b1; read_data = rand_line();
      cycle();
    end
    chk("bp fpu_ready at count 3", fpu_ready, 1'b0);
    read_data = rand_line();
    cycle();
    dram_ready = 1'b0;
    chk("bp in-flight no ovf", ovf_err, 1'b0);
    chk("bp full still requesting", request, 1'b1);
    delivered = 0;
    line_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dram_ready   = fpu_ready;
      read_data    = rand_line();
      request_done = !request && !cmd_ready;
      if (line_valid) delivered++;
      cycle();
    end
    clear_inputs();
    chk("bp delivered lines", delivered, 6);
    chk("bp back to idle", cmd_ready, 1'b1);

    // Overflow: fifth consecutive line with a full FIFO is dropped.
    do_reset();
    issue(32'h0000_0200, 8'd6);
    for (int i = 0; i < 5; i++) begin
      dram_ready = 1'b1; read_data = rand_line();
      cycle();
    end
    dram_ready = 1'b0;
    chk("ovf set", ovf_err, 1'b1);
    line_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("ovf sticky", ovf_err, 1'b1);
    do_reset();
    chk("ovf cleared by reset", ovf_err, 1'b0);

    // Simultaneous push/pop at count 2 across a 10-line command (pointer wrap).
    issue(32'h0000_0300, 8'd10);
    for (int i = 0; i < 2; i++) begin
      dram_ready = 1'b1; read_data = rand_line();
      cycle();
    end
    line_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dram_ready = 1'b1; read_data = rand_line();
      cycle();
      if (i < 7) chk($sformatf("pp%0d fpu_ready (count 2)", i), fpu_ready, 1'b1);
    end
    dram_ready = 1'b0;
    chk("pp final wait_done", request, 1'b0);
    request_done = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    clear_inputs();
    chk("pp drained", line_valid, 1'b0);

    // Reset in the middle of a fetch.
    do_reset();
    issue(32'h0000_0400, 8'd4);
    dram_ready = 1'b1; read_data = rand_line();
    cycle();
    dram_ready = 1'b0;
    chk("rst pre line_valid", line_valid, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst fifo empty", line_valid, 1'b0);
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst request", request, 1'b0);
    cycle();
    chk("rst idle next cycle", cmd_ready, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 499) != 0);
      cmd_valid    = ($urandom_range(0, 3) == 0);
      cmd_addr     = $urandom();
      cmd_lines    = SW'($urandom_range(0, 6));
      dram_ready   = fpu_ready ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      read_data    = rand_line();
      request_done = ($urandom_range(0, 2) == 0);
      line_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
